cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 193 +++++++++++++++++++
 tb/tb_cache_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// 4-way, 4-set write-back/write-allocate cache controller with MRU-bit replacement.
// One outstanding CPU request; misses go through optional writeback, then a fill.
module cache_controller (
   input  logic       clock,
   input  logic       reset,
   input  logic       cpu_req_valid,
   output logic       cpu_req_ready,
   input  logic       cpu_write,
   input  logic [1:0] cpu_set,
   input  logic [2:0] cpu_tag,
   input  logic [2:0] cpu_wdata,
   output logic       cpu_resp_valid,
   output logic       cpu_hit,
   output logic [2:0] cpu_rdata,
   output logic       mem_req_valid,
   input  logic       mem_req_ready,
   output logic       mem_write,
   output logic [4:0] mem_addr,
   output logic [2:0] mem_wdata,
   input  logic       mem_resp_valid,
   input  logic [2:0] mem_rdata
);

   localparam int WAYS = 4;
   localparam int SETS = 4;

   typedef enum logic [2:0] {
      IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP
   } state_t;

   state_t state_reg, state_next;

   logic       req_write_reg;
   logic [1:0] req_set_reg;
   logic [2:0] req_tag_reg;
   logic [2:0] req_wdata_reg;
   logic       hit_reg;
   logic [1:0] way_reg;

   logic       valid_reg [WAYS][SETS];
   logic       mru_reg   [WAYS][SETS];
   logic       dirty_reg [WAYS][SETS];
   logic [2:0] tag_reg   [WAYS][SETS];
   logic [2:0] data_reg  [WAYS][SETS];

   logic [3:0] way_valid, way_match, way_mru, way_dirty;
   logic       hit_any, victim_dirty, victim_found;
   logic [1:0] hit_way, victim_way;
   logic [3:0] mru_set, mru_upd;

   // Per-way view of the requested set, used for tag compare and victim choice.
   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_way
         assign way_valid[gi] = valid_reg[gi][req_set_reg];
         assign way_mru[gi]   = mru_reg[gi][req_set_reg];
         assign way_dirty[gi] = dirty_reg[gi][req_set_reg];
         assign way_match[gi] = valid_reg[gi][req_set_reg] &&
                                (tag_reg[gi][req_set_reg] == req_tag_reg);
      end
   endgenerate

   always_comb begin
      hit_any      = |way_match;
      hit_way      = 2'd0;
      victim_way   = 2'd0;
      victim_found = 1'b0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (way_match[i]) hit_way = 2'(i);
      end
      // Invalid ways take precedence over the MRU-clear candidates.
      for (int i = 0; i < WAYS; i++) begin
         if (!victim_found && !way_valid[i]) begin
            victim_way   = 2'(i);
            victim_found = 1'b1;
         end
      end
      for (int i = 0; i < WAYS; i++) begin
         if (!victim_found && !way_mru[i]) begin
            victim_way   = 2'(i);
            victim_found = 1'b1;
         end
      end
      victim_dirty = way_valid[victim_way] && way_dirty[victim_way];
   end

   // Once every way of a set is marked, only the latest access keeps its bit.
   always_comb begin
      mru_set = way_mru | (4'b0001 << way_reg);
      mru_upd = (&mru_set) ? (4'b0001 << way_reg) : mru_set;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (cpu_req_valid) state_next = LOOKUP;
         LOOKUP: begin
            if (hit_any)           state_next = RESP;
            else if (victim_dirty) state_next = WB_REQ;
            else                   state_next = FILL_REQ;
         end
         WB_REQ:    if (mem_req_ready)  state_next = WB_WAIT;
         WB_WAIT:   if (mem_resp_valid) state_next = FILL_REQ;
         FILL_REQ:  if (mem_req_ready)  state_next = FILL_WAIT;
         FILL_WAIT: if (mem_resp_valid) state_next = RESP;
         RESP:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Outputs are forced low while reset is asserted, even mid-transaction.
   always_comb begin
      cpu_req_ready  = 1'b0;
      cpu_resp_valid = 1'b0;
      cpu_hit        = 1'b0;
      cpu_rdata      = 3'd0;
      mem_req_valid  = 1'b0;
      mem_write      = 1'b0;
      mem_addr       = 5'd0;
      mem_wdata      = 3'd0;
      if (!reset) begin
         case (state_reg)
            IDLE: cpu_req_ready = 1'b1;
            WB_REQ: begin
               mem_req_valid = 1'b1;
               mem_write     = 1'b1;
               mem_addr      = {tag_reg[way_reg][req_set_reg], req_set_reg};
               mem_wdata     = data_reg[way_reg][req_set_reg];
            end
            FILL_REQ: begin
               mem_req_valid = 1'b1;
               mem_addr      = {req_tag_reg, req_set_reg};
            end
            RESP: begin
               cpu_resp_valid = 1'b1;
               cpu_hit        = hit_reg;
               cpu_rdata      = req_write_reg ? req_wdata_reg
                                              : data_reg[way_reg][req_set_reg];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         req_write_reg <= 1'b0;
         req_set_reg   <= 2'd0;
         req_tag_reg   <= 3'd0;
         req_wdata_reg <= 3'd0;
         hit_reg       <= 1'b0;
         way_reg       <= 2'd0;
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               valid_reg[w][s] <= 1'b0;
               mru_reg[w][s]   <= 1'b0;
               dirty_reg[w][s] <= 1'b0;
               tag_reg[w][s]   <= 3'd0;
               data_reg[w][s]  <= 3'd0;
            end
         end
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && cpu_req_valid) begin
            req_write_reg <= cpu_write;
            req_set_reg   <= cpu_set;
            req_tag_reg   <= cpu_tag;
            req_wdata_reg <= cpu_wdata;
         end
         if (state_reg == LOOKUP) begin
            hit_reg <= hit_any;
            way_reg <= hit_any ? hit_way : victim_way;
         end
         if (state_reg == FILL_WAIT && mem_resp_valid) begin
            valid_reg[way_reg][req_set_reg] <= 1'b1;
            dirty_reg[way_reg][req_set_reg] <= 1'b0;
            tag_reg[way_reg][req_set_reg]   <= req_tag_reg;
            data_reg[way_reg][req_set_reg]  <= mem_rdata;
         end
         if (state_reg == RESP) begin
            for (int w = 0; w < WAYS; w++) begin
               mru_reg[w][req_set_reg] <= mru_upd[w];
            end
            if (req_write_reg) begin
               data_reg[way_reg][req_set_reg]  <= req_wdata_reg;
               dirty_reg[way_reg][req_set_reg] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: table of CPU transactions with a responsive
// memory stub, plus hand-written backpressure and mid-transaction reset sequences.
module tb_cache_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic       cpu_req_valid, cpu_req_ready, cpu_write;
   logic [1:0] cpu_set;
   logic [2:0] cpu_tag, cpu_wdata;
   logic       cpu_resp_valid, cpu_hit;
   logic [2:0] cpu_rdata;
   logic       mem_req_valid, mem_req_ready, mem_write;
   logic [4:0] mem_addr;
   logic [2:0] mem_wdata;
   logic       mem_resp_valid;
   logic [2:0] mem_rdata;

   int n_cmp  = 0;
   int n_fail = 0;

   cache_controller dut (
      .clock(clock), .reset(reset),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_write(cpu_write), .cpu_set(cpu_set), .cpu_tag(cpu_tag),
      .cpu_wdata(cpu_wdata), .cpu_resp_valid(cpu_resp_valid),
      .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit         wr;
      logic [1:0] set;
      logic [2:0] tag;
      logic [2:0] wdata;
      logic [2:0] fill;
      bit         hit;
      logic [2:0] rdata;
      int         lat;
      bit         wb;
      logic [4:0] wb_addr;
      logic [2:0] wb_data;
      logic [4:0] fill_addr;
   } vec_t;

   vec_t vecs [20];

   function automatic vec_t mk(bit wr, logic [1:0] set, logic [2:0] tag,
                               logic [2:0] wdata, logic [2:0] fill, bit hit,
                               logic [2:0] rdata, int lat, bit wb,
                               logic [4:0] wb_addr, logic [2:0] wb_data,
                               logic [4:0] fill_addr);
      vec_t v;
      v.wr = wr; v.set = set; v.tag = tag; v.wdata = wdata; v.fill = fill;
      v.hit = hit; v.rdata = rdata; v.lat = lat; v.wb = wb;
      v.wb_addr = wb_addr; v.wb_data = wb_data; v.fill_addr = fill_addr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Issues one request and plays memory: accept every request at once, then
   // answer in the following cycle. Latency is counted from the handshake cycle.
   task automatic run_txn(input vec_t v, input string id);
      int         cyc = 1;
      int         pending = 0;
      bit         seen = 0, got_wb = 0, got_fill = 0;
      logic [4:0] wb_addr = 0, fill_addr = 0;
      logic [2:0] wb_data = 0, r_data = 0;
      logic       r_hit = 0;
      check({id, "_ready"}, cpu_req_ready, 1);
      cpu_req_valid = 1'b1;
      cpu_write = v.wr; cpu_set = v.set; cpu_tag = v.tag; cpu_wdata = v.wdata;
      step();
      cpu_req_valid = 1'b0;
      while (!seen && cyc < 40) begin
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 3'd0;
         if (cpu_resp_valid) begin
            seen = 1; r_hit = cpu_hit; r_data = cpu_rdata;
         end else begin
            if (mem_req_valid) begin
               if (mem_write) begin
                  got_wb = 1; wb_addr = mem_addr; wb_data = mem_wdata; pending = 1;
               end else begin
                  got_fill = 1; fill_addr = mem_addr; pending = 2;
               end
               mem_req_ready = 1'b1;
            end else if (pending != 0) begin
               mem_resp_valid = 1'b1;
               if (pending == 2) mem_rdata = v.fill;
               pending = 0;
            end
            step();
            cyc++;
         end
      end
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      check({id, "_resp_seen"}, seen, 1);
      check({id, "_hit"}, r_hit, v.hit);
      check({id, "_rdata"}, r_data, v.rdata);
      check({id, "_latency"}, cyc, v.lat);
      check({id, "_wb_req"}, got_wb, v.wb);
      if (v.wb) begin
         check({id, "_wb_addr"}, wb_addr, v.wb_addr);
         check({id, "_wb_data"}, wb_data, v.wb_data);
      end
      check({id, "_fill_req"}, got_fill, !v.hit);
      if (!v.hit) check({id, "_fill_addr"}, fill_addr, v.fill_addr);
      step();
      check({id, "_resp_one_cycle"}, cpu_resp_valid, 0);
      $display("txn %s: wr=%0d set=%0d tag=%0d hit=%0d rdata=%0d lat=%0d wb=%0d",
               id, v.wr, v.set, v.tag, r_hit, r_data, cyc, got_wb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //            wr set tag wd fill hit rd lat wb wbaddr     wbd fill_addr
      vecs[0]  = mk(0, 1, 3, 0, 5, 0, 5, 4, 0, 5'd0,      0, 5'b011_01);
      vecs[1]  = mk(0, 1, 3, 0, 0, 1, 5, 2, 0, 5'd0,      0, 5'd0);
      vecs[2]  = mk(1, 1, 3, 7, 0, 1, 7, 2, 0, 5'd0,      0, 5'd0);
      vecs[3]  = mk(0, 1, 4, 0, 2, 0, 2, 4, 0, 5'd0,      0, 5'b100_01);
      vecs[4]  = mk(0, 1, 5, 0, 3, 0, 3, 4, 0, 5'd0,      0, 5'b101_01);
      vecs[5]  = mk(0, 1, 6, 0, 4, 0, 4, 4, 0, 5'd0,      0, 5'b110_01);
      vecs[6]  = mk(0, 1, 7, 0, 6, 0, 6, 6, 1, 5'b011_01, 7, 5'b111_01);
      vecs[7]  = mk(0, 1, 3, 0, 1, 0, 1, 4, 0, 5'd0,      0, 5'b011_01);
      vecs[8]  = mk(0, 1, 5, 0, 0, 1, 3, 2, 0, 5'd0,      0, 5'd0);
      vecs[9]  = mk(0, 1, 7, 0, 0, 1, 6, 2, 0, 5'd0,      0, 5'd0);
      vecs[10] = mk(0, 2, 0, 0, 1, 0, 1, 4, 0, 5'd0,      0, 5'b000_10);
      vecs[11] = mk(0, 2, 1, 0, 2, 0, 2, 4, 0, 5'd0,      0, 5'b001_10);
      vecs[12] = mk(0, 2, 2, 0, 3, 0, 3, 4, 0, 5'd0,      0, 5'b010_10);
      vecs[13] = mk(0, 2, 3, 0, 4, 0, 4, 4, 0, 5'd0,      0, 5'b011_10);
      vecs[14] = mk(0, 2, 4, 0, 5, 0, 5, 4, 0, 5'd0,      0, 5'b100_10);
      vecs[15] = mk(0, 2, 1, 0, 0, 1, 2, 2, 0, 5'd0,      0, 5'd0);
      vecs[16] = mk(0, 2, 0, 0, 7, 0, 7, 4, 0, 5'd0,      0, 5'b000_10);
      vecs[17] = mk(0, 2, 3, 0, 0, 1, 4, 2, 0, 5'd0,      0, 5'd0);
      vecs[18] = mk(1, 0, 2, 3, 0, 0, 3, 4, 0, 5'd0,      0, 5'b010_00);
      vecs[19] = mk(0, 0, 2, 0, 0, 1, 3, 2, 0, 5'd0,      0, 5'd0);

      reset = 1'b1;
      cpu_req_valid = 0; cpu_write = 0; cpu_set = 0; cpu_tag = 0; cpu_wdata = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
      repeat (3) step();
      check("rst_cpu_req_ready", cpu_req_ready, 0);
      check("rst_cpu_resp_valid", cpu_resp_valid, 0);
      check("rst_cpu_hit", cpu_hit, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      reset = 1'b0;
      #1;
      check("post_rst_ready", cpu_req_ready, 1);
      step();

      for (int i = 0; i < 20; i++) run_txn(vecs[i], $sformatf("v%0d", i));

      // Fill request held off for 5 cycles; memory responses meanwhile are noise.
      check("bp_ready_idle", cpu_req_ready, 1);
      cpu_req_valid = 1'b1; cpu_write = 0; cpu_set = 2'd3; cpu_tag = 3'd1; cpu_wdata = 0;
      step();
      step();
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp%0d_mem_req_valid", k), mem_req_valid, 1);
         check($sformatf("bp%0d_mem_addr", k), mem_addr, 5'b001_11);
         check($sformatf("bp%0d_mem_write", k), mem_write, 0);
         check($sformatf("bp%0d_cpu_req_ready", k), cpu_req_ready, 0);
         mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 3'b010;
         step();
      end
      check("bp_hold_mem_req_valid", mem_req_valid, 1);
      check("bp_hold_mem_addr", mem_addr, 5'b001_11);
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 3'b010;
      step();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      check("bp_wait_mem_req_valid", mem_req_valid, 0);
      check("bp_wait_no_resp", cpu_resp_valid, 0);
      step();
      check("bp_wait2_no_resp", cpu_resp_valid, 0);
      cpu_req_valid = 1'b0;
      mem_resp_valid = 1'b1; mem_rdata = 3'b110;
      step();
      mem_resp_valid = 1'b0;
      check("bp_resp_valid", cpu_resp_valid, 1);
      check("bp_resp_hit", cpu_hit, 0);
      check("bp_resp_rdata", cpu_rdata, 3'b110);
      step();
      check("bp_resp_one_cycle", cpu_resp_valid, 0);
      $display("txn bp: set=3 tag=1 fill after 5 stalled cycles");
      run_txn(mk(0, 3, 1, 0, 0, 1, 6, 2, 0, 5'd0, 0, 5'd0), "bp_reread");

      // Reset while waiting for fill data abandons the request and the cache.
      check("rw_ready_idle", cpu_req_ready, 1);
      cpu_req_valid = 1'b1; cpu_write = 0; cpu_set = 2'd3; cpu_tag = 3'd5;
      step();
      cpu_req_valid = 1'b0;
      step();
      check("rw_fill_req", mem_req_valid, 1);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      check("rw_in_fill_wait", mem_req_valid, 0);
      reset = 1'b1;
      #1;
      check("rw_during_rst_ready", cpu_req_ready, 0);
      step();
      reset = 1'b0;
      #1;
      check("rw_after_mem_req_valid", mem_req_valid, 0);
      check("rw_after_ready", cpu_req_ready, 1);
      check("rw_after_no_resp", cpu_resp_valid, 0);
      step();
      check("rw_idle_no_resp", cpu_resp_valid, 0);
      $display("txn rw: reset during fill wait");
      run_txn(mk(0, 3, 5, 0, 1, 0, 1, 4, 0, 5'd0, 0, 5'b101_11), "rw_same_addr");
      run_txn(mk(0, 1, 7, 0, 2, 0, 2, 4, 0, 5'd0, 0, 5'b111_01), "rw_old_line");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
